// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage data memory, one write and one registered read port.
// Clears itself after reset; optional per-byte parity via DMEM_PARITY_EN.
//
// Ports:
//   clk, rst         clock; synchronous active-low reset
//   rd_en/rd_addr    read request; rd_data/rd_valid one cycle later
//   wr_en/wr_addr    write request with wr_data and per-byte wr_mask
//   busy             clear sweep running, requests ignored
//   parity_err       (DMEM_PARITY_EN) parity mismatch on returned word
//   par_inj          (DMEM_PARITY_EN) store inverted parity for this write
module data_mem_ctrl #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W/8-1:0] wr_mask,
    output logic              busy
`ifdef DMEM_PARITY_EN
    ,
    output logic              parity_err,
    input  logic              par_inj
`endif
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] clr_cnt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic              run;
    logic              wr_ok;
    logic              rd_ok;
    logic              rd_in;
    logic              fwd;
    logic [DATA_W-1:0] rd_word;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= (state == S_CLEAR) ? clr_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        unique case (state)
            S_CLEAR: begin
                busy = 1'b1;
                if (clr_cnt == LAST) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                state_nx = S_RUN;
            end
            default: begin
                state_nx = S_CLEAR;
            end
        endcase
    end

    // A write or read on the same edge as an asserted reset is dropped.
    assign clr_we = rst && (state == S_CLEAR);
    assign run    = rst && (state == S_RUN);
    assign wr_ok  = run && wr_en && ({1'b0, wr_addr} < DEPTH_X);
    assign rd_ok  = run && rd_en;
    assign rd_in  = {1'b0, rd_addr} < DEPTH_X;
    assign fwd    = wr_ok && (wr_addr == rd_addr);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Write-first: enabled bytes of a same-address write bypass the array.
    always_comb begin
        rd_word = '0;
        if (rd_in) begin
            rd_word = mem[rd_addr];
            for (int i = 0; i < NB; i++) begin
                if (fwd && wr_mask[i]) begin
                    rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] wr_par;
    logic [NB-1:0] rd_par;
    logic          rd_perr;

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            wr_par[i] = (^wr_data[8*i +: 8]) ^ par_inj;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_mem[clr_cnt] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_mask[i]) begin
                    par_mem[wr_addr][i] <= wr_par[i];
                end
            end
        end
    end

    always_comb begin
        rd_par  = '0;
        rd_perr = 1'b0;
        if (rd_in) begin
            rd_par = par_mem[rd_addr];
            for (int i = 0; i < NB; i++) begin
                if (fwd && wr_mask[i]) begin
                    rd_par[i] = wr_par[i];
                end
                if ((^rd_word[8*i +: 8]) != rd_par[i]) begin
                    rd_perr = 1'b1;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data    <= '0;
            rd_valid   <= 1'b0;
`ifdef DMEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (rd_ok) begin
            rd_data    <= rd_word;
            rd_valid   <= 1'b1;
`ifdef DMEM_PARITY_EN
            parity_err <= rd_perr;
`endif
        end else begin
            rd_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of data_mem_ctrl.
// Second instance uses DEPTH=1000 for out-of-range addresses.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_mask;
    logic        par_inj;

    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        parity_err;
    logic [15:0] rd_data2;
    logic        rd_valid2;
    logic        busy2;
    logic        parity_err2;

    int total;
    int bad;

    data_mem_ctrl #(.DATA_W(16), .DEPTH(1024), .ADDR_W(10)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .busy      (busy)
`ifdef DMEM_PARITY_EN
        ,
        .parity_err(parity_err),
        .par_inj   (par_inj)
`endif
    );

    data_mem_ctrl #(.DATA_W(16), .DEPTH(1000), .ADDR_W(10)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data2),
        .rd_valid  (rd_valid2),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .busy      (busy2)
`ifdef DMEM_PARITY_EN
        ,
        .parity_err(parity_err2),
        .par_inj   (par_inj)
`endif
    );

`ifndef DMEM_PARITY_EN
    assign parity_err  = 1'b0;
    assign parity_err2 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [9:0] a, input logic [15:0] d,
                         input logic [1:0] m);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_rd(input logic [9:0] a);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1100 && busy; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL reset_busy got=%b exp=1", busy);
        end
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL reset_rd got=%b/%h exp=0/0000", rd_valid, rd_data);
        end
`ifdef DMEM_PARITY_EN
        total++;
        if (parity_err !== 1'b0) begin
            bad++; $display("FAIL reset_perr got=%b exp=0", parity_err);
        end
`endif
        rst = 1'b1;
        wait_idle();
    endtask

    task automatic test_clear_sweep();
        int n;
        int n2;
        logic [9:0] addrs [3];
        addrs[0] = 10'd0; addrs[1] = 10'd513; addrs[2] = 10'd1023;
        for (int i = 0; i < 3; i++) do_wr(addrs[i], 16'hA5C3, 2'b11);
        do_rd(10'd513);
        total++;
        if (rd_data !== 16'hA5C3) begin
            bad++; $display("FAIL preload got=%h exp=a5c3", rd_data);
        end
        rst = 1'b0;
        step();
        total++;
        if (busy !== 1'b1 || rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL rst_again got=%b/%h exp=1/0000", busy, rd_data);
        end
        rst = 1'b1;
        n = 0; n2 = 0;
        while (busy && n < 2000) begin
            step();
            n++;
            if (!busy2 && n2 == 0) n2 = n;
        end
        total++;
        if (n !== 1024) begin
            bad++; $display("FAIL busy_len got=%0d exp=1024", n);
        end
        total++;
        if (n2 !== 1000) begin
            bad++; $display("FAIL busy_len2 got=%0d exp=1000", n2);
        end
        for (int i = 0; i < 3; i++) begin
            do_rd(addrs[i]);
            total++;
            if (rd_valid !== 1'b1 || rd_data !== 16'h0000) begin
                bad++;
                $display("FAIL cleared_%0d got=%b/%h exp=1/0000",
                         addrs[i], rd_valid, rd_data);
            end
        end
        step();
        total++;
        if (rd_valid !== 1'b0) begin
            bad++; $display("FAIL valid_pulse got=%b exp=0", rd_valid);
        end
    endtask

    task automatic test_byte_mask();
        do_wr(10'd5, 16'hBEEF, 2'b11);
        do_rd(10'd5);
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF) begin
            bad++;
            $display("FAIL wr_full got=%b/%h exp=1/beef", rd_valid, rd_data);
        end
        do_wr(10'd5, 16'h1234, 2'b01);
        do_rd(10'd5);
        total++;
        if (rd_data !== 16'hBE34) begin
            bad++; $display("FAIL wr_lo got=%h exp=be34", rd_data);
        end
        do_wr(10'd5, 16'h56FF, 2'b10);
        do_rd(10'd5);
        total++;
        if (rd_data !== 16'h5634) begin
            bad++; $display("FAIL wr_hi got=%h exp=5634", rd_data);
        end
        do_wr(10'd5, 16'hFFFF, 2'b00);
        step();
        total++;
        if (rd_data !== 16'h5634) begin
            bad++; $display("FAIL rd_hold got=%h exp=5634", rd_data);
        end
        do_rd(10'd5);
        total++;
        if (rd_data !== 16'h5634) begin
            bad++; $display("FAIL mask0 got=%h exp=5634", rd_data);
        end
    endtask

    task automatic test_rdw_forward();
        do_wr(10'd7, 16'h1111, 2'b11);
        wr_en = 1'b1; wr_addr = 10'd7; wr_data = 16'hAAAA; wr_mask = 2'b10;
        rd_en = 1'b1; rd_addr = 10'd7;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 16'hAA11) begin
            bad++;
            $display("FAIL rdw_fwd got=%b/%h exp=1/aa11", rd_valid, rd_data);
        end
        do_rd(10'd7);
        total++;
        if (rd_data !== 16'hAA11) begin
            bad++; $display("FAIL rdw_after got=%h exp=aa11", rd_data);
        end
        wr_en = 1'b1; wr_addr = 10'd8; wr_data = 16'h5555; wr_mask = 2'b11;
        rd_en = 1'b1; rd_addr = 10'd5;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        total++;
        if (rd_data !== 16'h5634) begin
            bad++; $display("FAIL diff_addr_rd got=%h exp=5634", rd_data);
        end
        do_rd(10'd8);
        total++;
        if (rd_data !== 16'h5555) begin
            bad++; $display("FAIL diff_addr_wr got=%h exp=5555", rd_data);
        end
    endtask

    task automatic test_out_of_range();
        do_rd(10'd5);
        total++;
        if (rd_data2 !== 16'h5634) begin
            bad++; $display("FAIL oor_pre got=%h exp=5634", rd_data2);
        end
        do_wr(10'd1000, 16'hFFFF, 2'b11);
        do_rd(10'd1000);
        total++;
        if (rd_valid2 !== 1'b1 || rd_data2 !== 16'h0000) begin
            bad++;
            $display("FAIL oor_rd got=%b/%h exp=1/0000", rd_valid2, rd_data2);
        end
        total++;
        if (rd_data !== 16'hFFFF) begin
            bad++; $display("FAIL inrange_1000 got=%h exp=ffff", rd_data);
        end
        do_rd(10'd999);
        total++;
        if (rd_data2 !== 16'h0000) begin
            bad++; $display("FAIL oor_999 got=%h exp=0000", rd_data2);
        end
        do_rd(10'd8);
        total++;
        if (rd_data2 !== 16'h5555) begin
            bad++; $display("FAIL oor_8 got=%h exp=5555", rd_data2);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        int vbad;
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 300; i++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        rd_en = 1'b1; rd_addr = 10'd8;
        wr_en = 1'b1; wr_addr = 10'd5; wr_data = 16'hFFFF; wr_mask = 2'b11;
        n = 0; vbad = 0;
        while (busy && n < 2000) begin
            step();
            n++;
            if (rd_valid !== 1'b0) vbad++;
        end
        rd_en = 1'b0; wr_en = 1'b0;
        total++;
        if (n !== 1024) begin
            bad++; $display("FAIL restart_len got=%0d exp=1024", n);
        end
        total++;
        if (vbad !== 0) begin
            bad++; $display("FAIL busy_rd_valid got=%0d exp=0", vbad);
        end
        do_rd(10'd5);
        total++;
        if (rd_data !== 16'h0000) begin
            bad++; $display("FAIL busy_wr got=%h exp=0000", rd_data);
        end
        do_rd(10'd8);
        total++;
        if (rd_data !== 16'h0000) begin
            bad++; $display("FAIL restart_clr got=%h exp=0000", rd_data);
        end
    endtask

`ifdef DMEM_PARITY_EN
    task automatic test_parity();
        par_inj = 1'b1;
        do_wr(10'd9, 16'h00FF, 2'b11);
        par_inj = 1'b0;
        do_rd(10'd9);
        total++;
        if (rd_data !== 16'h00FF || parity_err !== 1'b1) begin
            bad++;
            $display("FAIL par_inj got=%h/%b exp=00ff/1", rd_data, parity_err);
        end
        do_wr(10'd9, 16'h00FF, 2'b11);
        do_rd(10'd9);
        total++;
        if (parity_err !== 1'b0) begin
            bad++; $display("FAIL par_ok got=%b exp=0", parity_err);
        end
        par_inj = 1'b1;
        wr_en = 1'b1; wr_addr = 10'd9; wr_data = 16'h7000; wr_mask = 2'b10;
        rd_en = 1'b1; rd_addr = 10'd9;
        step();
        wr_en = 1'b0; rd_en = 1'b0; par_inj = 1'b0;
        total++;
        if (rd_data !== 16'h70FF || parity_err !== 1'b1) begin
            bad++;
            $display("FAIL par_fwd got=%h/%b exp=70ff/1", rd_data, parity_err);
        end
        do_rd(10'd1000);
        total++;
        if (rd_valid2 !== 1'b1 || parity_err2 !== 1'b0) begin
            bad++;
            $display("FAIL par_oor got=%b/%b exp=1/0", rd_valid2, parity_err2);
        end
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        rst = 1'b0; rd_en = 1'b0; rd_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        par_inj = 1'b0;
        step();
        test_reset();
        test_clear_sweep();
        test_byte_mask();
        test_rdw_forward();
        test_out_of_range();
        test_reset_mid_sweep();
`ifdef DMEM_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
